// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - CSR instruction sequencer between decode and the CSR register file
// Optional local mcycle/minstret counters: define CSR_COUNTERS_EN.
module csr_access_unit #(
  parameter int unsigned STRICT_RO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_instr_31_12,
  input  logic [31:0] req_rs1_val,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal,
  output logic        csr_we,
  output logic [19:0] csr_instr_31_12,
  output logic [31:0] csr_wd,
  input  logic [31:0] csr_rd,
  input  logic        retire
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [19:0] r_instr;
  logic [31:0] r_rs1;
  logic [31:0] r_rdata;
  logic        r_illegal;

  logic [2:0]  w_funct3;
  logic [4:0]  w_src;
  logic        w_wants_write;
  logic        w_ro;
  logic        w_illegal;
  logic        w_write_ok;
  logic [31:0] w_rd;

  // Field decode of the held instruction
  assign w_funct3 = r_instr[2:0];
  assign w_src    = r_instr[7:3];
  // Set/clear forms with a zero source are pure reads
  assign w_wants_write = !(w_funct3[1] && (w_src == 5'd0));
  assign w_ro          = (r_instr[19:18] == 2'b11);
  assign w_illegal     = (w_funct3[1:0] == 2'b00) ||
                         ((STRICT_RO != 0) && w_ro && w_wants_write);
  // Read-only targets never get written; in non-strict mode the write is just dropped
  assign w_write_ok    = (r_state == S_EXEC) && !w_illegal && w_wants_write && !w_ro;

`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic [63:0] w_mcycle_nxt;
  logic [63:0] w_minstret_nxt;
  logic [11:0] w_addr;
  logic        w_local_hit;
  logic        w_local_wr;
  logic        w_sel_instret;
  logic        w_sel_hi;
  logic [31:0] w_local_rd;
  logic [31:0] w_operand;
  logic [31:0] w_new;

  assign w_addr        = r_instr[19:8];
  // addr[1] picks minstret over mcycle, addr[7] picks the high half
  assign w_sel_instret = w_addr[1];
  assign w_sel_hi      = w_addr[7];

  // Match the counter addresses and their read-only shadows
  always_comb begin
    w_local_hit = 1'b0;
    case (w_addr)
      12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: w_local_hit = 1'b1;
      default:                            w_local_hit = 1'b0;
    endcase
  end

  assign w_local_rd = w_sel_instret ? (w_sel_hi ? r_minstret[63:32] : r_minstret[31:0])
                                    : (w_sel_hi ? r_mcycle[63:32]   : r_mcycle[31:0]);
  assign w_rd       = w_local_hit ? w_local_rd : csr_rd;
  assign w_operand  = w_funct3[2] ? {27'd0, w_src} : r_rs1;
  assign w_local_wr = w_write_ok && w_local_hit;
  assign csr_we     = w_write_ok && !w_local_hit;

  // Apply csrrw/csrrs/csrrc semantics to the selected counter half
  always_comb begin
    w_new = w_rd;
    case (w_funct3[1:0])
      2'b01:   w_new = w_operand;
      2'b10:   w_new = w_rd | w_operand;
      2'b11:   w_new = w_rd & ~w_operand;
      default: w_new = w_rd;
    endcase
  end

  // Counter next-state: increment first, then let a local write override one half
  always_comb begin
    w_mcycle_nxt   = r_mcycle + 64'd1;
    w_minstret_nxt = r_minstret + {63'd0, retire};
    if (w_local_wr) begin
      if (!w_sel_instret) begin
        if (w_sel_hi) w_mcycle_nxt[63:32] = w_new;
        else          w_mcycle_nxt[31:0]  = w_new;
      end else begin
        if (w_sel_hi) w_minstret_nxt[63:32] = w_new;
        else          w_minstret_nxt[31:0]  = w_new;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else begin
      r_mcycle   <= w_mcycle_nxt;
      r_minstret <= w_minstret_nxt;
    end
  end
`else
  logic w_unused_retire;

  assign w_unused_retire = retire;
  assign w_rd            = csr_rd;
  assign csr_we          = w_write_ok;
`endif

  // Request/execute/response sequencer with captured instruction and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_instr   <= 20'd0;
      r_rs1     <= 32'd0;
      r_rdata   <= 32'd0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_instr <= req_instr_31_12;
            r_rs1   <= req_rs1_val;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rdata   <= w_illegal ? 32'd0 : w_rd;
          r_illegal <= w_illegal;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready       = (r_state == S_IDLE);
  assign resp_valid      = (r_state == S_RESP);
  assign resp_rdata      = r_rdata;
  assign resp_illegal    = r_illegal;
  assign csr_instr_31_12 = r_instr;
  assign csr_wd          = r_rs1;

endmodule
